// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the shared-memory bus arbiter.
// Imported by the arbiter top and its round-robin selector.
package mem_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 2;
  localparam int unsigned DATA_W_DEF = 2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first requester found
// searching upward from (rr_ptr + 1) mod N, wrapping around.
module rr_pick #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] rr_ptr,
  output logic [IdxW-1:0] idx,
  output logic            any_req
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  int unsigned    first;
  int unsigned    pick;

  always_comb begin
    req_dbl = {req, req};
    // Bit j of req_rot belongs to master (rr_ptr + 1 + j) mod N.
    req_rot = N'(req_dbl >> (32'(rr_ptr) + 32'd1));
    first   = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req_rot[j]) first = j;
    end
    pick = 32'(rr_ptr) + 32'd1 + first;
    if (pick >= N) pick = pick - N;
    idx     = IdxW'(pick);
    any_req = |req;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory between N_MASTERS masters,
// one transaction in flight at a time (IDLE -> ISSUE -> [WAIT] -> DONE).
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_we,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [N_MASTERS-1:0]          m_gnt,
  output logic [N_MASTERS-1:0]          m_done,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);

  localparam int unsigned IdxW = $clog2(N_MASTERS);
  localparam int unsigned LatW = $clog2(MEM_LAT + 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [IdxW-1:0]     rr_q, rr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LatW-1:0]     lat_q, lat_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [IdxW-1:0]     pick_idx;
  logic                any_req;

  rr_pick #(
    .N    (N_MASTERS),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req     (m_req),
    .rr_ptr  (rr_q),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          idx_d   = pick_idx;
          we_d    = m_we[pick_idx];
          addr_d  = m_addr[pick_idx * ADDR_W +: ADDR_W];
          wdata_d = m_wdata[pick_idx * DATA_W +: DATA_W];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StDone;
        end else begin
          lat_d   = LatW'(MEM_LAT);
          state_d = StWait;
        end
      end
      StWait: begin
        lat_d = lat_q - LatW'(1);
        // Last wait cycle: memory data is valid now.
        if (lat_q == LatW'(1)) begin
          rdata_d = mem_rdata;
          state_d = StDone;
        end
      end
      StDone: begin
        rr_d    = idx_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      rr_q    <= IdxW'(N_MASTERS - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lat_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode purely from registered state so they drop with async reset.
  always_comb begin
    m_gnt     = '0;
    m_done    = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state_q != StIdle);
    if (state_q != StIdle) m_gnt[idx_q] = 1'b1;
    if (state_q == StDone) m_done[idx_q] = 1'b1;
    if (state_q == StIssue) begin
      mem_en    = 1'b1;
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
  end

  assign m_rdata = rdata_q;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(m_gnt));
  a_en_single:  assert property (@(posedge clk) disable iff (!rst_n) mem_en |=> !mem_en);
  a_done_gnt:   assert property (@(posedge clk) disable iff (!rst_n) (m_done & ~m_gnt) == '0);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: a transaction-level round-robin/latency
// model predicts grants, memory strobes, completions and read data.
module tb_mem_bus_arbiter;

  localparam int unsigned N    = 2;
  localparam int unsigned AW   = 2;
  localparam int unsigned DW   = 2;
  localparam int unsigned NDUT = 2;

  typedef struct packed {
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic            drop;
  } dir_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mem_clr;
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;

  logic [N-1:0]    gnt       [NDUT];
  logic [N-1:0]    done      [NDUT];
  logic [DW-1:0]   rdata     [NDUT];
  logic            mem_en    [NDUT];
  logic            mem_we    [NDUT];
  logic [AW-1:0]   mem_addr  [NDUT];
  logic [DW-1:0]   mem_wdata [NDUT];
  logic [DW-1:0]   mem_rdata [NDUT];
  logic            busy      [NDUT];

  int sel;
  int lat;
  int n_checks;
  int n_errors;
  int rr_last;
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] ref_rdata;
  logic [N-1:0]  just_served;
  bit            rst_armed;
  bit            force_m0;
  dir_t          rows [7];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int unsigned Lat = (k == 0) ? 1 : 3;
    logic [DW-1:0] mem  [2**AW];
    logic [DW-1:0] pipe [Lat];

    mem_bus_arbiter #(
      .N_MASTERS (N),
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .MEM_LAT   (Lat)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m_req     (m_req),
      .m_we      (m_we),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_gnt     (gnt[k]),
      .m_done    (done[k]),
      .m_rdata   (rdata[k]),
      .mem_en    (mem_en[k]),
      .mem_we    (mem_we[k]),
      .mem_addr  (mem_addr[k]),
      .mem_wdata (mem_wdata[k]),
      .mem_rdata (mem_rdata[k]),
      .busy      (busy[k])
    );

    // Memory model: read data appears Lat cycles after the strobe, junk otherwise.
    always @(posedge clk) begin
      if (mem_clr) begin
        for (int a = 0; a < 2**AW; a++) mem[a] <= '0;
      end else if (mem_en[k] && mem_we[k]) begin
        mem[mem_addr[k]] <= mem_wdata[k];
      end
      pipe[0] <= (mem_en[k] && !mem_we[k]) ? mem[mem_addr[k]] : DW'($urandom);
      for (int s = 1; s < Lat; s++) pipe[s] <= pipe[s-1];
    end
    assign mem_rdata[k] = pipe[Lat-1];
  end

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (sel == 0) ? g_dut[0].mem[a] : g_dut[1].mem[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic start_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"},  gnt[sel], 0);
    check({tag, "_done"}, done[sel], 0);
    check({tag, "_busy"}, busy[sel], 0);
    check({tag, "_en"},   mem_en[sel], 0);
    check({tag, "_rd"},   rdata[sel], ref_rdata);
  endtask

  task automatic full_reset();
    rst_n   = 1'b0;
    mem_clr = 1'b1;
    m_req   = '1;
    m_we    = '1;
    m_addr  = AW'($urandom);
    m_wdata = DW'($urandom);
    ref_rdata = '0;
    repeat (3) begin
      @(negedge clk);
      check_quiet("rst");
      check("rst_mwe", mem_we[sel], 0);
      check("rst_maddr", mem_addr[sel], 0);
    end
    start_cycle();
    m_req   = '0;
    rst_n   = 1'b1;
    mem_clr = 1'b0;
    rr_last = N - 1;
    for (int a = 0; a < 2**AW; a++) ref_mem[a] = '0;
    just_served = '0;
    force_m0    = 1'b0;
  endtask

  // Asynchronous reset in the middle of a read wait: transaction is abandoned.
  task automatic mid_reset();
    rst_n     = 1'b0;
    ref_rdata = '0;
    rst_armed = 1'b0;
    #1;
    check_quiet("arst");
    check("arst_mwe", mem_we[sel], 0);
    check("arst_mwdata", mem_wdata[sel], 0);
    repeat (2) begin
      @(negedge clk);
      check_quiet("arst_hold");
    end
    start_cycle();
    m_req       = '0;
    rst_n       = 1'b1;
    rr_last     = N - 1;
    just_served = '0;
    force_m0    = 1'b1;
  endtask

  task automatic run_round(input bit dir, input dir_t row);
    int            w;
    int            last_c;
    logic          lw;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    bit            do_drop;
    start_cycle();
    if (dir) begin
      m_req   = row.req;
      m_we    = row.we;
      m_addr  = row.addr;
      m_wdata = row.wdata;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (just_served[i] && $urandom_range(1, 0) == 0) m_req[i] = 1'b0;
        if (!m_req[i] && ($urandom_range(1, 0) == 1 || (force_m0 && i == 0))) begin
          m_req[i]             = 1'b1;
          m_we[i]              = 1'($urandom_range(1, 0));
          m_addr[i*AW +: AW]   = AW'($urandom);
          m_wdata[i*DW +: DW]  = DW'($urandom);
        end
      end
      force_m0 = 1'b0;
    end
    just_served = '0;
    @(negedge clk);
    check_quiet("idle");
    if (m_req == '0) return;

    w = -1;
    for (int k = 1; k <= N; k++) begin
      if (w < 0 && m_req[(rr_last + k) % N]) w = (rr_last + k) % N;
    end
    lw     = m_we[w];
    la     = m_addr[w*AW +: AW];
    ld     = m_wdata[w*DW +: DW];
    last_c = lw ? 2 : 2 + lat;

    for (int c = 1; c <= last_c; c++) begin
      start_cycle();
      if (c == 1 && !dir) begin
        // Payload changes after the latch must be ignored.
        m_we[w]             = 1'($urandom_range(1, 0));
        m_addr[w*AW +: AW]  = AW'($urandom);
        m_wdata[w*DW +: DW] = DW'($urandom);
      end
      if (c == 2 && !lw) begin
        do_drop = dir ? row.drop : ($urandom_range(3, 0) == 0);
        if (do_drop) m_req[w] = 1'b0;
        if (rst_armed) begin
          mid_reset();
          return;
        end
      end
      @(negedge clk);
      if (c == last_c) begin
        if (lw) ref_mem[la] = ld;
        else    ref_rdata   = ref_mem[la];
      end
      check("gnt",  gnt[sel], N'(1) << w);
      check("busy", busy[sel], 1);
      check("en",   mem_en[sel], (c == 1) ? 1 : 0);
      check("done", done[sel], (c == last_c) ? (N'(1) << w) : 0);
      check("rdata", rdata[sel], ref_rdata);
      if (c == 1) begin
        check("mwe",    mem_we[sel], lw);
        check("maddr",  mem_addr[sel], la);
        check("mwdata", mem_wdata[sel], ld);
      end
      if (c == last_c && lw) check("mem", mem_word(la), ld);
    end
    rr_last = w;
    if (m_req[w]) just_served[w] = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    sel       = 0;
    lat       = 1;
    rst_armed = 1'b0;
    rows[0] = '{req: 2'b11, we: 2'b11, addr: 4'b1110, wdata: 4'b1001, drop: 1'b0};
    rows[1] = rows[0];
    rows[2] = rows[0];
    rows[3] = rows[0];
    rows[4] = '{req: 2'b01, we: 2'b01, addr: 4'b0001, wdata: 4'b0011, drop: 1'b0};
    rows[5] = '{req: 2'b01, we: 2'b00, addr: 4'b0001, wdata: 4'b0000, drop: 1'b0};
    rows[6] = '{req: 2'b10, we: 2'b00, addr: 4'b0100, wdata: 4'b0000, drop: 1'b1};

    full_reset();
    for (int r = 0; r < 7; r++) run_round(1'b1, rows[r]);
    for (int r = 0; r < 60; r++) run_round(1'b0, rows[0]);
    rst_armed = 1'b1;
    run_round(1'b1, rows[5]);
    check("arst_taken", rst_armed, 0);
    for (int r = 0; r < 60; r++) run_round(1'b0, rows[0]);

    sel = 1;
    lat = 3;
    full_reset();
    for (int r = 4; r < 7; r++) run_round(1'b1, rows[r]);
    for (int r = 0; r < 40; r++) run_round(1'b0, rows[0]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
